// File: rtl/multi_cycle_add_sub_module_pkg.sv
// rtl/multi_cycle_add_sub_module_pkg.sv - shared state encoding and sizing helpers
package multi_cycle_add_sub_module_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter to keep the RTL uniform.
    function automatic int calc_cnt_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunk_ripple_adder_module.sv
// rtl/chunk_ripple_adder_module.sv - combinational CHUNK-bit ripple-carry slice
module chunk_ripple_adder_module #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        one_bit_full_adder_gatelevel_module u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[CHUNK];
    // Carry into the top bit is exposed so the top level can form signed overflow.
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/one_bit_full_adder_gatelevel_module.sv
// rtl/one_bit_full_adder_gatelevel_module.sv - gate-level one-bit full adder
module one_bit_full_adder_gatelevel_module (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;
    logic g;
    logic t;

    xor g_x1 (p, a, b);
    xor g_x2 (sum, p, cin);
    and g_a1 (g, a, b);
    and g_a2 (t, p, cin);
    or  g_o1 (cout, g, t);

endmodule

// File: rtl/multi_cycle_add_sub_module.sv
// rtl/multi_cycle_add_sub_module.sv - chunk-serial adder/subtractor with valid/ready/done handshake
module multi_cycle_add_sub_module
    import multi_cycle_add_sub_module_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             done
);

    localparam int            NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int            CW     = calc_cnt_w(NCHUNK);
    localparam logic [CW-1:0] LAST   = CW'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_width_check
        $error("WIDTH must be a multiple of CHUNK");
    end

    logic [0:0]       state;
    logic [CW-1:0]    k;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_upd;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_c_msb;
    int               base;

    assign in_ready = (state == ST_IDLE);

    always_comb begin
        base    = int'(k) * CHUNK;
        a_chunk = a_reg[base +: CHUNK];
        b_chunk = b_reg[base +: CHUNK];
        acc_upd = acc;
        acc_upd[base +: CHUNK] = chunk_sum;
    end

    chunk_ripple_adder_module #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry),
        .sum   (chunk_sum),
        .cout  (chunk_cout),
        .c_msb (chunk_c_msb)
    );

    // Partial results build up in acc so sum only changes on the final-chunk edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            k        <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            acc      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (in_valid) begin
                    a_reg <= a;
                    b_reg <= b ^ {WIDTH{sub}};
                    carry <= cin ^ sub;
                    k     <= '0;
                    state <= ST_RUN;
                end
            end else begin
                acc   <= acc_upd;
                carry <= chunk_cout;
                k     <= k + 1'b1;
                if (k == LAST) begin
                    sum      <= acc_upd;
                    cout     <= chunk_cout;
                    overflow <= chunk_c_msb ^ chunk_cout;
                    done     <= 1'b1;
                    state    <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_cycle_add_sub_module.sv
// tb/tb_multi_cycle_add_sub_module.sv - directed and swept checks of the chunk-serial adder/subtractor
module tb_multi_cycle_add_sub_module;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v32 = 1'b0, cin32 = 1'b0, sub32 = 1'b0;
    logic        r32, co32, ov32, d32;
    logic [31:0] a32 = '0, b32 = '0, s32;

    logic        v16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
    logic        r16, co16, ov16, d16;
    logic [15:0] a16 = '0, b16 = '0, s16;

    logic        v24 = 1'b0, cin24 = 1'b0, sub24 = 1'b0;
    logic        r24, co24, ov24, d24;
    logic [23:0] a24 = '0, b24 = '0, s24;

    int nvec = 0;
    int nerr = 0;

    multi_cycle_add_sub_module #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .a(a32), .b(b32),
        .cin(cin32), .sub(sub32), .sum(s32), .cout(co32), .overflow(ov32), .done(d32)
    );

    multi_cycle_add_sub_module #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16),
        .cin(cin16), .sub(sub16), .sum(s16), .cout(co16), .overflow(ov16), .done(d16)
    );

    multi_cycle_add_sub_module #(.WIDTH(24), .CHUNK(4)) u_dut24 (
        .clk(clk), .rst_n(rst_n), .in_valid(v24), .in_ready(r24), .a(a24), .b(b24),
        .cin(cin24), .sub(sub24), .sum(s24), .cout(co24), .overflow(ov24), .done(d24)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int sel, output int cyc);
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if ((sel == 0 && d32) || (sel == 1 && d16) || (sel == 2 && d24)) break;
        end
    endtask

    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb, input logic [31:0] es,
                         input logic eco, input logic eov);
        int cyc;
        a32 = a; b32 = b; cin32 = ci; sub32 = sb; v32 = 1'b1;
        @(posedge clk);
        #1;
        v32 = 1'b0;
        wait_done(0, cyc);
        chk($sformatf("%s latency", tag), cyc, 4);
        chk($sformatf("%s sum", tag), s32, es);
        chk($sformatf("%s cout", tag), co32, eco);
        chk($sformatf("%s overflow", tag), ov32, eov);
    endtask

    initial begin
        int cyc;
        int seen;
        logic [23:0] ra, rb, bb;
        logic        rc, rs, eov;
        logic [24:0] tot;

        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", r32, 1'b1);
        chk("reset sum", s32, 32'h0);
        chk("reset cout", co32, 1'b0);
        chk("reset overflow", ov32, 1'b0);
        chk("reset done", d32, 1'b0);
        rst_n = 1'b1;

        run32("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run32("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run32("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run32("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run32("sub_brw",  32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 1'b0);

        // in_valid stays high with a second op on the bus for the whole first run
        a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; sub32 = 1'b0; v32 = 1'b1;
        @(posedge clk);
        #1;
        a32 = 32'h1234_5678; b32 = 32'h1111_1111;
        wait_done(0, cyc);
        chk("busy latency", cyc, 4);
        chk("busy first sum", s32, 32'h0000_0000);
        chk("busy first cout", co32, 1'b1);
        chk("busy in_ready at done", r32, 1'b1);
        @(posedge clk);
        #1;
        v32 = 1'b0;
        chk("b2b accepted", r32, 1'b0);
        chk("b2b done low", d32, 1'b0);
        wait_done(0, cyc);
        chk("b2b latency", cyc, 4);
        chk("b2b sum", s32, 32'h2345_6789);
        chk("b2b cout", co32, 1'b0);

        // abort an op with a one-edge reset during its second RUN cycle
        a32 = 32'h0000_0001; b32 = 32'h0000_0001; v32 = 1'b1;
        @(posedge clk);
        #1;
        v32 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort in_ready", r32, 1'b1);
        chk("abort sum", s32, 32'h0);
        chk("abort cout", co32, 1'b0);
        chk("abort overflow", ov32, 1'b0);
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (d32) seen++;
        end
        chk("abort no done", seen, 0);

        // single-chunk configuration
        a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1; sub16 = 1'b0; v16 = 1'b1;
        @(posedge clk);
        #1;
        v16 = 1'b0;
        wait_done(1, cyc);
        chk("w16 latency", cyc, 1);
        chk("w16 sum", s16, 16'hFFFF);
        chk("w16 cout", co16, 1'b1);
        chk("w16 overflow", ov16, 1'b0);

        // random sweep, 24-bit in 4-bit chunks, against a +/- (b, cin) model
        for (int i = 0; i < 12; i++) begin
            ra = 24'($urandom);
            rb = 24'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            bb  = rs ? ~rb : rb;
            tot = {1'b0, ra} + {1'b0, bb} + {24'h0, rc ^ rs};
            eov = (ra[23] == bb[23]) && (tot[23] != ra[23]);
            a24 = ra; b24 = rb; cin24 = rc; sub24 = rs; v24 = 1'b1;
            @(posedge clk);
            #1;
            v24 = 1'b0;
            wait_done(2, cyc);
            chk($sformatf("rnd%0d latency", i), cyc, 6);
            chk($sformatf("rnd%0d sum", i), s24, tot[23:0]);
            chk($sformatf("rnd%0d cout", i), co24, tot[24]);
            chk($sformatf("rnd%0d overflow", i), ov24, eov);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
